// File: rtl/custom_sequence_checker.sv
// custom_sequence_checker
//   Receive-side monitor for the 8-code custom sequence
//   0000->1101->1011->1001->0110->1100->0011->1111->0000.
//   Hunts for a legal code, counts consecutive in-sequence samples until
//   LOCK_LEN is reached, then predicts each next code. While locked it
//   flags and counts mismatches, and it drops lock after LOSS_LEN
//   consecutive misses.
//   Optional feature macro: CUSTOM_SEQ_RESYNC_EN. When it is defined, a
//   legal mismatching code seen while locked re-seeds the prediction from
//   the observed code instead of flywheeling from the old prediction.
module custom_sequence_checker #(
  parameter int LOCK_LEN = 3,
  parameter int LOSS_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             valid,
  input  logic [3:0]       q_in,
  input  logic             err_clr,
  output logic             locked,
  output logic [3:0]       expected,
  output logic             err,
  output logic             illegal,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_LEN_C = LOCK_LEN[3:0];
  localparam logic [3:0]       LOSS_LEN_C = LOSS_LEN[3:0];
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO   = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

  // Successor of a sequence code; illegal codes map to 0000.
  function automatic logic [3:0] seq_next(input logic [3:0] code);
    logic [3:0] nxt;
    case (code)
      4'd0:    nxt = 4'd13;
      4'd13:   nxt = 4'd11;
      4'd11:   nxt = 4'd9;
      4'd9:    nxt = 4'd6;
      4'd6:    nxt = 4'd12;
      4'd12:   nxt = 4'd3;
      4'd3:    nxt = 4'd15;
      4'd15:   nxt = 4'd0;
      default: nxt = 4'd0;
    endcase
    return nxt;
  endfunction

  // True when the code is one of the eight sequence members.
  function automatic logic seq_legal(input logic [3:0] code);
    logic ok;
    case (code)
      4'd0, 4'd13, 4'd11, 4'd9, 4'd6, 4'd12, 4'd3, 4'd15: ok = 1'b1;
      default:                                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [3:0]       run_cnt_r;
  logic [3:0]       run_cnt_s;
  logic [3:0]       miss_cnt_r;
  logic [3:0]       miss_cnt_s;
  logic             locked_s;
  logic [3:0]       expected_s;
  logic             err_s;
  logic             illegal_s;
  logic [ERR_W-1:0] err_count_s;
  logic             inc_s;
  logic             legal_s;
  logic             match_s;

  // Next-state, prediction and pulse computation for one sampled code.
  always_comb begin
    state_s    = state_r;
    run_cnt_s  = run_cnt_r;
    miss_cnt_s = miss_cnt_r;
    locked_s   = locked;
    expected_s = expected;
    err_s      = 1'b0;
    illegal_s  = 1'b0;
    inc_s      = 1'b0;
    legal_s    = seq_legal(q_in);
    match_s    = (q_in == expected);

    if (valid) begin
      illegal_s = ~legal_s;
      case (state_r)
        HUNT: begin
          if (legal_s) begin
            expected_s = seq_next(q_in);
            run_cnt_s  = 4'd1;
            state_s    = SYNC;
          end else begin
            state_s = HUNT;
          end
        end
        SYNC: begin
          if (match_s) begin
            run_cnt_s  = run_cnt_r + 4'd1;
            expected_s = seq_next(q_in);
            if ((run_cnt_r + 4'd1) == LOCK_LEN_C) begin
              state_s    = LOCK;
              locked_s   = 1'b1;
              miss_cnt_s = 4'd0;
            end else begin
              state_s = SYNC;
            end
          end else if (legal_s) begin
            // A legal but wrong code restarts the run from this sample.
            run_cnt_s  = 4'd1;
            expected_s = seq_next(q_in);
            state_s    = SYNC;
          end else begin
            state_s = HUNT;
          end
        end
        LOCK: begin
          if (match_s) begin
            expected_s = seq_next(q_in);
            miss_cnt_s = 4'd0;
            state_s    = LOCK;
          end else begin
            err_s      = 1'b1;
            inc_s      = 1'b1;
            miss_cnt_s = miss_cnt_r + 4'd1;
`ifdef CUSTOM_SEQ_RESYNC_EN
            if (legal_s) begin
              expected_s = seq_next(q_in);
            end else begin
              expected_s = seq_next(expected);
            end
`else
            expected_s = seq_next(expected);
`endif
            if ((miss_cnt_r + 4'd1) == LOSS_LEN_C) begin
              state_s    = HUNT;
              locked_s   = 1'b0;
              expected_s = 4'd0;
              miss_cnt_s = 4'd0;
            end else begin
              state_s = LOCK;
            end
          end
        end
        default: begin
          state_s    = HUNT;
          locked_s   = 1'b0;
          expected_s = 4'd0;
          run_cnt_s  = 4'd0;
          miss_cnt_s = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    // A clear coinciding with a new mismatch keeps that mismatch.
    if (err_clr) begin
      err_count_s = inc_s ? ERR_ONE : ERR_ZERO;
    end else if (inc_s) begin
      err_count_s = (err_count == ERR_MAX) ? err_count : (err_count + ERR_ONE);
    end else begin
      err_count_s = err_count;
    end
  end

  // State, counters and all outputs are registered; clear resets asynchronously.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_r    <= HUNT;
      run_cnt_r  <= 4'd0;
      miss_cnt_r <= 4'd0;
      locked     <= 1'b0;
      expected   <= 4'd0;
      err        <= 1'b0;
      illegal    <= 1'b0;
      err_count  <= ERR_ZERO;
    end else begin
      state_r    <= state_s;
      run_cnt_r  <= run_cnt_s;
      miss_cnt_r <= miss_cnt_s;
      locked     <= locked_s;
      expected   <= expected_s;
      err        <= err_s;
      illegal    <= illegal_s;
      err_count  <= err_count_s;
    end
  end

endmodule

// File: tb/tb_custom_sequence_checker.sv
// Scoreboard bench for custom_sequence_checker. Stimulus steps push the
// hand-computed response into a queue at the falling edge; a monitor pops
// and compares just after each rising edge. Instance a uses default
// parameters, instance b uses ERR_W=2 / LOSS_LEN=15 for saturation.
module tb_custom_sequence_checker;

  typedef struct packed {
    logic       locked;
    logic [3:0] expected;
    logic       err;
    logic       illegal;
    logic [7:0] err_count;
  } resp_t;

  logic clk = 1'b0;
  logic clear_a = 1'b0, valid_a = 1'b0, err_clr_a = 1'b0;
  logic [3:0] q_a = 4'd0;
  logic locked_a, err_a, illegal_a;
  logic [3:0] expected_a;
  logic [7:0] err_count_a;

  logic clear_b = 1'b0, valid_b = 1'b0, err_clr_b = 1'b0;
  logic [3:0] q_b = 4'd0;
  logic locked_b, err_b, illegal_b;
  logic [3:0] expected_b;
  logic [1:0] err_count_b;

  resp_t qa[$];
  resp_t qb[$];
  int checks = 0;
  int passes = 0;

  // Sequence order used to derive expected codes by index.
  logic [3:0] seq [8] = '{4'd0, 4'd13, 4'd11, 4'd9, 4'd6, 4'd12, 4'd3, 4'd15};

  always #5 clk = ~clk;

  custom_sequence_checker #(.LOCK_LEN(3), .LOSS_LEN(2), .ERR_W(8)) dut_a (
    .clk(clk), .clear(clear_a), .valid(valid_a), .q_in(q_a), .err_clr(err_clr_a),
    .locked(locked_a), .expected(expected_a), .err(err_a), .illegal(illegal_a),
    .err_count(err_count_a));

  custom_sequence_checker #(.LOCK_LEN(3), .LOSS_LEN(15), .ERR_W(2)) dut_b (
    .clk(clk), .clear(clear_b), .valid(valid_b), .q_in(q_b), .err_clr(err_clr_b),
    .locked(locked_b), .expected(expected_b), .err(err_b), .illegal(illegal_b),
    .err_count(err_count_b));

  function automatic resp_t r(input logic l, input logic [3:0] e, input logic er,
                              input logic il, input logic [7:0] c);
    resp_t x;
    x.locked = l; x.expected = e; x.err = er; x.illegal = il; x.err_count = c;
    return x;
  endfunction

  task automatic compare(input string name, input resp_t got, input resp_t want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got locked=%0d exp=%h err=%0d illegal=%0d cnt=%0d, want locked=%0d exp=%h err=%0d illegal=%0d cnt=%0d",
                  name, got.locked, got.expected, got.err, got.illegal, got.err_count,
                  want.locked, want.expected, want.err, want.illegal, want.err_count);
  endtask

  // Monitor: pop one expected response per stimulus step, just after the edge.
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) compare("dut_a", r(locked_a, expected_a, err_a, illegal_a, err_count_a), qa.pop_front());
    if (qb.size() > 0) compare("dut_b", r(locked_b, expected_b, err_b, illegal_b, {6'd0, err_count_b}), qb.pop_front());
  end

  task automatic step_a(input logic c, input logic v, input logic [3:0] q,
                        input logic ec, input resp_t e);
    @(negedge clk);
    clear_a = c; valid_a = v; q_a = q; err_clr_a = ec;
    qa.push_back(e);
  endtask

  task automatic step_b(input logic c, input logic v, input logic [3:0] q,
                        input logic ec, input resp_t e);
    @(negedge clk);
    clear_b = c; valid_b = v; q_b = q; err_clr_b = ec;
    qb.push_back(e);
  endtask

  initial begin
    resp_t zero;
    zero = r(1'b0, 4'd0, 1'b0, 1'b0, 8'd0);

    // Reset held with random valid codes, then released with valid low.
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 4'($urandom_range(15, 0)), 1'b0, zero);
    step_a(1'b1, 1'b0, 4'd5, 1'b0, zero);
    step_a(1'b1, 1'b0, 4'd0, 1'b0, zero);

    // Acquire: 0000, 1101, 1011 -> locked, expecting 1001.
    step_a(1'b1, 1'b1, 4'd0,  1'b0, r(1'b0, 4'd13, 1'b0, 1'b0, 8'd0));
    step_a(1'b1, 1'b1, 4'd13, 1'b0, r(1'b0, 4'd11, 1'b0, 1'b0, 8'd0));
    step_a(1'b1, 1'b1, 4'd11, 1'b0, r(1'b1, 4'd9,  1'b0, 1'b0, 8'd0));

    // Sixteen in-sequence samples including the 1111->0000 wrap, with a valid gap.
    for (int i = 0; i < 16; i++) begin
      step_a(1'b1, 1'b1, seq[(3 + i) % 8], 1'b0, r(1'b1, seq[(4 + i) % 8], 1'b0, 1'b0, 8'd0));
      if (i == 7) step_a(1'b1, 1'b0, 4'd5, 1'b0, r(1'b1, seq[(4 + i) % 8], 1'b0, 1'b0, 8'd0));
    end

    // Single error: expecting 0110 after this match, then 1100 is wrong.
    step_a(1'b1, 1'b1, 4'd9, 1'b0, r(1'b1, 4'd6, 1'b0, 1'b0, 8'd0));
`ifdef CUSTOM_SEQ_RESYNC_EN
    step_a(1'b1, 1'b1, 4'd12, 1'b0, r(1'b1, 4'd3,  1'b1, 1'b0, 8'd1));
    step_a(1'b1, 1'b1, 4'd3,  1'b0, r(1'b1, 4'd15, 1'b0, 1'b0, 8'd1));
`else
    step_a(1'b1, 1'b1, 4'd12, 1'b0, r(1'b1, 4'd12, 1'b1, 1'b0, 8'd1));
    step_a(1'b1, 1'b1, 4'd12, 1'b0, r(1'b1, 4'd3,  1'b0, 1'b0, 8'd1));
    step_a(1'b1, 1'b1, 4'd3,  1'b0, r(1'b1, 4'd15, 1'b0, 1'b0, 8'd1));
`endif

    // err_clr alone zeroes the count.
    step_a(1'b1, 1'b0, 4'd0, 1'b1, r(1'b1, 4'd15, 1'b0, 1'b0, 8'd0));

    // Loss of lock: two illegal 0101 samples.
    step_a(1'b1, 1'b1, 4'd5, 1'b0, r(1'b1, 4'd0, 1'b1, 1'b1, 8'd1));
    step_a(1'b1, 1'b1, 4'd5, 1'b0, r(1'b0, 4'd0, 1'b1, 1'b1, 8'd2));

    // HUNT/SYNC paths: illegal in HUNT, legal restart in SYNC, illegal drop from SYNC.
    step_a(1'b1, 1'b1, 4'd7,  1'b0, r(1'b0, 4'd0,  1'b0, 1'b1, 8'd2));
    step_a(1'b1, 1'b1, 4'd6,  1'b0, r(1'b0, 4'd12, 1'b0, 1'b0, 8'd2));
    step_a(1'b1, 1'b1, 4'd9,  1'b0, r(1'b0, 4'd6,  1'b0, 1'b0, 8'd2));
    step_a(1'b1, 1'b1, 4'd4,  1'b0, r(1'b0, 4'd6,  1'b0, 1'b1, 8'd2));
    step_a(1'b1, 1'b1, 4'd3,  1'b0, r(1'b0, 4'd15, 1'b0, 1'b0, 8'd2));
    step_a(1'b1, 1'b1, 4'd15, 1'b0, r(1'b0, 4'd0,  1'b0, 1'b0, 8'd2));
    step_a(1'b1, 1'b1, 4'd0,  1'b0, r(1'b1, 4'd13, 1'b0, 1'b0, 8'd2));

    // Mid-operation clear acts without a clock edge.
    step_a(1'b0, 1'b1, 4'd13, 1'b0, zero);
    #1;
    compare("async_clear", r(locked_a, expected_a, err_a, illegal_a, err_count_a), zero);
    step_a(1'b1, 1'b0, 4'd0, 1'b0, zero);
    @(negedge clk);
    valid_a = 1'b0;

    // Instance b: saturation at 3 with ERR_W=2, LOSS_LEN=15 keeps lock.
    step_b(1'b0, 1'b0, 4'd0, 1'b0, zero);
    step_b(1'b1, 1'b1, 4'd0,  1'b0, r(1'b0, 4'd13, 1'b0, 1'b0, 8'd0));
    step_b(1'b1, 1'b1, 4'd13, 1'b0, r(1'b0, 4'd11, 1'b0, 1'b0, 8'd0));
    step_b(1'b1, 1'b1, 4'd11, 1'b0, r(1'b1, 4'd9,  1'b0, 1'b0, 8'd0));
    step_b(1'b1, 1'b1, 4'd5, 1'b0, r(1'b1, 4'd6,  1'b1, 1'b1, 8'd1));
    step_b(1'b1, 1'b1, 4'd5, 1'b0, r(1'b1, 4'd12, 1'b1, 1'b1, 8'd2));
    step_b(1'b1, 1'b1, 4'd5, 1'b0, r(1'b1, 4'd3,  1'b1, 1'b1, 8'd3));
    step_b(1'b1, 1'b1, 4'd5, 1'b0, r(1'b1, 4'd15, 1'b1, 1'b1, 8'd3));
    step_b(1'b1, 1'b1, 4'd5, 1'b0, r(1'b1, 4'd0,  1'b1, 1'b1, 8'd3));
    // err_clr with a mismatch on the same edge leaves a count of 1.
    step_b(1'b1, 1'b1, 4'd5, 1'b1, r(1'b1, 4'd13, 1'b1, 1'b1, 8'd1));
    step_b(1'b1, 1'b0, 4'd5, 1'b1, r(1'b1, 4'd13, 1'b0, 1'b0, 8'd0));
    @(negedge clk);
    valid_b = 1'b0; err_clr_b = 1'b0;

    // Drain the scoreboard within a fixed cycle budget.
    repeat (4) @(negedge clk);
    checks++;
    if (qa.size() == 0 && qb.size() == 0) passes++;
    else $display("FAIL drain: got %0d/%0d entries left, want 0/0", qa.size(), qb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/custom_sequence_checker.md
# custom_sequence_checker

Receive-side companion to the 4-bit custom sequence generator: it monitors a 4-bit bus that should step 0000→1101→1011→1001→0110→1100→0011→1111→0000. It acquires lock on the sequence, predicts the next code, and flags and counts deviations. It sits downstream of the generator, or at the far end of any link carrying it, as a self-check and link-integrity monitor.

## Interface
Parameters:
- LOCK_LEN, 3: consecutive in-sequence samples needed to lock; legal range 2..15.
- LOSS_LEN, 2: consecutive mismatches while locked that drop lock; legal range 1..15.
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clear  in  1  reset, asynchronous, active-low.
- valid  in  1  q_in is sampled only on edges where valid=1.
- q_in  in  4  observed sequence value.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCK.
- expected  out  4  predicted next code.
- err  out  1  one-cycle pulse: a locked-state mismatch was sampled.
- illegal  out  1  one-cycle pulse: the sampled code is not one of the 8 sequence codes.
- err_count  out  ERR_W  saturating mismatch count.

## Operation
- next() map: 0→13, 13→11, 11→9, 9→6, 6→12, 12→3, 3→15, 15→0. Codes 1,2,4,5,7,8,10,14 are illegal.
- Internal run_cnt and miss_cnt are each 4 bits.
- States: HUNT, SYNC, LOCK. Reset: state HUNT, run_cnt=0, miss_cnt=0, locked=0, expected=0000, err=0, illegal=0, err_count=0.
- valid=0: state, counters and expected hold; err and illegal are 0.
- illegal = 1 on any valid sample of an illegal code, in any state.
- HUNT:
  - legal sample: expected←next(q_in), run_cnt←1, go to SYNC.
  - illegal sample: stay in HUNT.
- SYNC:
  - q_in==expected: run_cnt+1; expected←next(q_in). When run_cnt+1==LOCK_LEN, go to LOCK and set miss_cnt←0.
  - legal mismatch: run_cnt←1, expected←next(q_in), stay in SYNC.
  - illegal mismatch: go to HUNT.
  - No err pulses and no err_count increments in SYNC.
- LOCK:
  - match: expected←next(q_in), miss_cnt←0.
  - mismatch, legal or illegal: err=1, err_count+1 (saturating at all-ones), miss_cnt+1, expected←next(expected) (flywheel).
  - When miss_cnt+1==LOSS_LEN: go to HUNT, locked←0, expected←0000.
- err_clr together with an increment on the same edge gives err_count=1. err_clr alone gives 0.
- Mid-operation clear assertion returns all state to reset values immediately, without waiting for a clock edge.

## Timing
- All outputs are registered and update on the edge that samples the causing input. err and illegal are high for exactly the following cycle.
- locked rises on the edge capturing the LOCK_LEN-th consecutive in-sequence sample. For LOCK_LEN=3, that is the 3rd valid edge after entering SYNC with 0000.
- locked falls on the edge capturing the LOSS_LEN-th consecutive mismatch.
- Wrap-around 1111→0000 is a normal match.
- Gaps in valid do not break a run.
- err_count saturates at 2^ERR_W−1 and holds.

## Configuration
- CUSTOM_SEQ_RESYNC_EN defined: in LOCK, a mismatch with a legal code sets expected←next(q_in) instead of next(expected). err and err_count still register the mismatch, and miss_cnt still advances.
- Undefined: flywheel prediction as described in Operation.

## Test plan
- Reset: hold clear=0 with clk running and random q_in → all outputs 0, expected=0000. Release clear, drive valid=0 → no change.
- Acquire: valid stream 0000,1101,1011 → locked=1 after the 3rd edge, expected=1001. Continue 16 correct samples including the 1111→0000 wrap → err never pulses, err_count=0.
- Single error: locked, expect 0110, drive 1100 → err pulse, err_count=1, expected=1100 (flywheel). Next sample 1100 → match, locked stays 1.
- Loss of lock: locked, drive 0101 twice → illegal pulses twice, err_count=2, locked=0 after the 2nd edge, expected=0000, state HUNT.
- Saturation and clear: ERR_W=2, force 5 mismatches with LOSS_LEN=15 → err_count=3. err_clr together with a mismatch → err_count=1.
- With CUSTOM_SEQ_RESYNC_EN: locked, expect 1001, drive 0011 → err=1, expected=1111.
